// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and back-pressure counter.
// Define PIPE_SKID_EN for a registered in_ready with a one-word skid buffer.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              CLRn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_xfer;
    logic              out_xfer;
    logic              stall;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_v & out_ready;
    assign stall    = main_v & ~out_ready & ~flush;

`ifdef PIPE_SKID_EN
    logic              skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // skid_v is a flop, so in_ready has no path from out_ready
    assign in_ready = ~skid_v;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
            skid_v    <= 1'b0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
            skid_v    <= 1'b0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (out_xfer || !main_v) begin
            if (skid_v) begin
                main_v    <= 1'b1;
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                skid_v    <= 1'b0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else if (in_xfer) begin
                main_v    <= 1'b1;
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
            end
        end else if (in_xfer) begin
            skid_v    <= 1'b1;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end
`else
    assign in_ready = out_ready | ~main_v;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (in_xfer) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (out_xfer) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default and CNT_W=4 instances).
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        CLRn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  in_ctrl2 = '0;
    logic [31:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [7:0]  out_ctrl2;
    logic [31:0] out_data2;
    logic [3:0]  stall_cnt2;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg dut (
        .CLK(CLK), .CLRn(CLRn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut4 (
        .CLK(CLK), .CLRn(CLRn), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_ctrl(in_ctrl2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_ctrl(out_ctrl2), .out_data(out_data2),
        .stall_cnt(stall_cnt2)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        flush = 0; in_valid = 0; out_ready = 0;
        in_valid2 = 0; out_ready2 = 0;
        CLRn = 0;
        step(); step();
        CLRn = 1;
        step();
    endtask

    task automatic test_reset();
        CLRn = 0;
        step();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        nvec++;
        if (out_ctrl !== 8'h00 || out_data !== 32'h0) begin
            nerr++; $display("FAIL rst_payload: got %h/%h want 0/0", out_ctrl, out_data);
        end
        nvec++;
        if (stall_cnt !== 16'h0) begin
            nerr++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL rst_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1; in_ctrl = 8'h5A; in_data = 32'hDEADBEEF; out_ready = 1;
        step();
        in_valid = 0;
        nvec++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h5A || out_data !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL single: got v=%b c=%h d=%h want v=1 c=5a d=deadbeef",
                     out_valid, out_ctrl, out_data);
        end
        step();
        nvec++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            nerr++; $display("FAIL single_drain: got v=%b c=%h want 0/00", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_ctrl = 8'(i); in_data = 32'(i);
            step();
            nvec++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 8'(i)) begin
                nerr++;
                $display("FAIL stream[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
            end
        end
        in_valid = 0;
        step();
        nvec++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'h0) begin
            nerr++; $display("FAIL stream_end: got v=%b cnt=%0d want 0/0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_stall();
        bit acc;
        do_reset();
        in_valid = 1; in_ctrl = 8'h11; in_data = 32'hA1;
        step();
        in_ctrl = 8'h22; in_data = 32'hB2;
        for (int k = 0; k < 5; k++) begin
            acc = in_ready;
            step();
            if (acc) in_valid = 0;
            nvec++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'h11 || out_data !== 32'hA1) begin
                nerr++;
                $display("FAIL stall_hold[%0d]: got v=%b c=%h d=%h want 1/11/a1",
                         k, out_valid, out_ctrl, out_data);
            end
        end
        nvec++;
        if (stall_cnt !== 16'd5) begin
            nerr++; $display("FAIL stall_cnt5: got %0d want 5", stall_cnt);
        end
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++; $display("FAIL stall_ready: got %b want 0", in_ready);
        end
        out_ready = 1;
        #1;
        nvec++;
        if (in_ready !== !SKID) begin
            nerr++; $display("FAIL ready_path: got %b want %b", in_ready, !SKID);
        end
        acc = in_ready;
        step();
        if (acc) in_valid = 0;
        nvec++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h22 || out_data !== 32'hB2) begin
            nerr++;
            $display("FAIL release: got v=%b c=%h d=%h want 1/22/b2", out_valid, out_ctrl, out_data);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL release_ready: got %b want 1", in_ready);
        end
        in_valid = 0;
        step();
        nvec++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || stall_cnt !== 16'd5) begin
            nerr++;
            $display("FAIL release_end: got v=%b c=%h cnt=%0d want 0/00/5", out_valid, out_ctrl, stall_cnt);
        end
    endtask

    task automatic test_flush();
        bit acc;
        do_reset();
        in_valid = 1; in_ctrl = 8'h11; in_data = 32'hA1;
        step();
        in_ctrl = 8'h22; in_data = 32'hB2;
        acc = in_ready;
        step();
        if (acc) in_valid = 0;
        flush = 1; in_valid = 1; in_ctrl = 8'h33; in_data = 32'hC3;
        step();
        flush = 0; in_valid = 0;
        nvec++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h0) begin
            nerr++;
            $display("FAIL flush: got v=%b c=%h d=%h want 0/00/0", out_valid, out_ctrl, out_data);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL flush_ready: got %b want 1", in_ready);
        end
        nvec++;
        if (stall_cnt !== 16'd1) begin
            nerr++; $display("FAIL flush_cnt: got %0d want 1", stall_cnt);
        end
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            nvec++;
            if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
                nerr++;
                $display("FAIL flush_ghost[%0d]: got v=%b c=%h d=%h want v=0", k, out_valid, out_ctrl, out_data);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid2 = 1; in_ctrl2 = 8'h44; in_data2 = 32'h0BAD_F00D;
        step();
        in_valid2 = 0;
        repeat (15) step();
        nvec++;
        if (stall_cnt2 !== 4'd15) begin
            nerr++; $display("FAIL sat15: got %0d want 15", stall_cnt2);
        end
        repeat (5) step();
        nvec++;
        if (stall_cnt2 !== 4'd15) begin
            nerr++; $display("FAIL sat20: got %0d want 15", stall_cnt2);
        end
        nvec++;
        if (out_valid2 !== 1'b1 || out_data2 !== 32'h0BAD_F00D || out_ctrl2 !== 8'h44) begin
            nerr++;
            $display("FAIL sat_hold: got v=%b c=%h d=%h want 1/44/0badf00d", out_valid2, out_ctrl2, out_data2);
        end
        #2 CLRn = 0;
        #1;
        nvec++;
        if (out_valid2 !== 1'b0 || out_ctrl2 !== 8'h00 || out_data2 !== 32'h0 || stall_cnt2 !== 4'd0) begin
            nerr++;
            $display("FAIL async_rst: got v=%b c=%h d=%h cnt=%0d want all 0",
                     out_valid2, out_ctrl2, out_data2, stall_cnt2);
        end
        nvec++;
        if (in_ready2 !== 1'b1) begin
            nerr++; $display("FAIL async_rst_ready: got %b want 1", in_ready2);
        end
        out_ready2 = 1;
        step();
        CLRn = 1;
        step(); step();
        nvec++;
        if (out_valid2 !== 1'b0 || out_ctrl2 !== 8'h00) begin
            nerr++; $display("FAIL post_rst: got v=%b c=%h want 0/00", out_valid2, out_ctrl2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
